// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage valid/ready RISC-V immediate decoder and sign-extender
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3, F_U = 3'd4, F_J = 3'd5, F_X = 3'd7;
  logic             s1_valid_q, s2_valid_q;
  logic [31:0]      s1_instr_q;
  logic [TAG_W-1:0] s1_tag_q, s2_tag_q;
  logic [2:0]       s1_fmt_q, s2_fmt_q, fmt_d;
  logic [XLEN-1:0]  s2_imm_q;
  logic             s2_illegal_q;
  logic [31:0]      imm32_d;
  logic             adv1, adv2, accept;
  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1 && !flush;
  assign accept   = in_valid && in_ready;
  // Opcode to format; every listed opcode ends in 2'b11, so other low bits fall to illegal
  always_comb begin
    case (in_instr[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: fmt_d = F_I;
      7'b0100011: fmt_d = F_S;
      7'b1100011: fmt_d = F_B;
      7'b0110111, 7'b0010111: fmt_d = F_U;
      7'b1101111: fmt_d = F_J;
      7'b0110011: fmt_d = F_R;
      default:    fmt_d = F_X;
    endcase
  end
  // Reassemble the scattered immediate bits of the stage-1 instruction as a 32-bit signed value
  always_comb begin
    case (s1_fmt_q)
      F_I:     imm32_d = {{20{s1_instr_q[31]}}, s1_instr_q[31:20]};
      F_S:     imm32_d = {{20{s1_instr_q[31]}}, s1_instr_q[31:25], s1_instr_q[11:7]};
      F_B:     imm32_d = {{19{s1_instr_q[31]}}, s1_instr_q[31], s1_instr_q[7], s1_instr_q[30:25], s1_instr_q[11:8], 1'b0};
      F_U:     imm32_d = {s1_instr_q[31:12], 12'b0};
      F_J:     imm32_d = {{11{s1_instr_q[31]}}, s1_instr_q[31], s1_instr_q[19:12], s1_instr_q[20], s1_instr_q[30:21], 1'b0};
      default: imm32_d = '0;
    endcase
  end
  // Stage 1: capture instruction, tag and decoded format on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_tag_q   <= '0;
      s1_fmt_q   <= F_R;
    end else begin
      s1_valid_q <= flush ? 1'b0 : (adv1 ? accept : s1_valid_q);
      if (accept) begin
        s1_instr_q <= in_instr;
        s1_tag_q   <= in_tag;
        s1_fmt_q   <= fmt_d;
      end
    end
  end
  // Stage 2: register the extended immediate; data only moves on advance so stalled outputs hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_imm_q     <= '0;
      s2_fmt_q     <= F_R;
      s2_illegal_q <= 1'b0;
      s2_tag_q     <= '0;
    end else begin
      s2_valid_q <= flush ? 1'b0 : (adv2 ? s1_valid_q : s2_valid_q);
      if (adv2 && s1_valid_q) begin
        s2_imm_q     <= XLEN'($signed(imm32_d));
        s2_fmt_q     <= s1_fmt_q;
        s2_illegal_q <= s1_fmt_q == F_X;
        s2_tag_q     <= s1_tag_q;
      end
    end
  end
  assign out_valid   = s2_valid_q;
  assign out_imm     = s2_imm_q;
  assign out_fmt     = s2_fmt_q;
  assign out_illegal = s2_illegal_q;
  assign out_tag     = s2_tag_q;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed vectors, corner sequences and randomized scoreboard for imm_gen_pipe
module tb_imm_gen_pipe;
  logic        clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [7:0]  in_tag = '0;
  logic        in_ready, out_valid, out_illegal, in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_imm;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt, out_fmt64;
  logic [7:0]  out_tag, out_tag64;
  int          checks = 0, errors = 0, cyc = 0;
  logic        ir_seen;
  logic [7:0]  got[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_tag(out_tag64));

  typedef struct {logic [31:0] instr; logic [7:0] tag; int acc;} ent_t;
  typedef struct {logic [31:0] instr; logic [31:0] imm32; logic [63:0] imm64; logic [2:0] fmt; logic ill;} vec_t;
  ent_t q[$];
  vec_t vecs[$];
  logic [6:0] ops[11] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decoder: field values by arithmetic, sign applied by subtracting 2^width
  function automatic void ref_dec(input logic [31:0] i, output logic [63:0] imm, output logic [2:0] fmt, output logic ill);
    longint v;
    v = 0;
    fmt = 3'd7;
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin
        fmt = 3'd1; v = longint'(i[31:20]); if (v >= 2048) v -= 4096;
      end
      7'h23: begin
        fmt = 3'd2; v = longint'(i[31:25]) * 32 + longint'(i[11:7]); if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        fmt = 3'd3;
        v = longint'(i[31]) * 4096 + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
        if (v >= 4096) v -= 8192;
      end
      7'h37, 7'h17: begin
        fmt = 3'd4; v = longint'(i[31:12]) * 4096; if (i[31]) v -= longint'(1) << 32;
      end
      7'h6F: begin
        fmt = 3'd5;
        v = longint'(i[31]) * (longint'(1) << 20) + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
        if (v >= (longint'(1) << 20)) v -= longint'(1) << 21;
      end
      7'h33: fmt = 3'd0;
      default: fmt = 3'd7;
    endcase
    ill = fmt == 3'd7;
    imm = v;
  endfunction

  // One cycle: inputs were driven at the negedge; check mid-cycle, then advance the model on the edge
  task automatic tick();
    logic [63:0] ri;
    logic [2:0]  rf;
    logic        rl;
    bit          er, ev, xi, xo;
    #1;
    er = !flush && (q.size() < 2 || out_ready);
    ev = q.size() > 0 && q[0].acc < cyc;
    ir_seen = in_ready;
    chk("in_ready", in_ready, er);
    chk("in_ready64", in_ready64, er);
    chk("out_valid", out_valid, ev);
    chk("out_valid64", out_valid64, ev);
    if (ev) begin
      ref_dec(q[0].instr, ri, rf, rl);
      chk("out_imm", out_imm, ri[31:0]);
      chk("out_imm64", out_imm64, ri);
      chk("out_fmt", out_fmt, rf);
      chk("out_fmt64", out_fmt64, rf);
      chk("out_illegal", out_illegal, rl);
      chk("out_illegal64", out_illegal64, rl);
      chk("out_tag", out_tag, q[0].tag);
      chk("out_tag64", out_tag64, q[0].tag);
    end
    xi = in_valid && er;
    xo = ev && out_ready;
    @(posedge clk);
    cyc++;
    if (xo) got.push_back(q[0].tag);
    if (flush) q.delete();
    else begin
      if (xo) void'(q.pop_front());
      if (xi) q.push_back('{in_instr, in_tag, cyc});
    end
    @(negedge clk);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_valid"}, out_valid, 0);
    chk({name, "_imm"}, out_imm, 0);
    chk({name, "_imm64"}, out_imm64, 0);
    chk({name, "_fmt"}, out_fmt, 0);
    chk({name, "_illegal"}, out_illegal, 0);
    chk({name, "_tag"}, out_tag, 0);
    chk({name, "_valid64"}, out_valid64, 0);
  endtask

  initial begin
    vecs.push_back('{32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0});
    vecs.push_back('{32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0});
    vecs.push_back('{32'hFE000CE3, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 3'd3, 1'b0});
    vecs.push_back('{32'h001000EF, 32'h00000800, 64'h00000000_00000800, 3'd5, 1'b0});
    vecs.push_back('{32'h800002B7, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4, 1'b0});
    vecs.push_back('{32'h0000007F, 32'h00000000, 64'h0, 3'd7, 1'b1});
    vecs.push_back('{32'h00B50533, 32'h00000000, 64'h0, 3'd0, 1'b0});
    vecs.push_back('{32'h7FF00093, 32'h000007FF, 64'h00000000_000007FF, 3'd1, 1'b0});
    vecs.push_back('{32'h00000001, 32'h00000000, 64'h0, 3'd7, 1'b1});
    vecs.push_back('{32'h12345037, 32'h12345000, 64'h00000000_12345000, 3'd4, 1'b0});

    #2 rst_n = 1'b0;
    #1 chk_zero("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    out_ready = 1'b1;
    foreach (vecs[n]) begin
      in_valid = 1'b1; in_instr = vecs[n].instr; in_tag = 8'(n + 1);
      tick();
      in_valid = 1'b0;
      chk("vec_early_valid", out_valid, 0);
      tick();
      chk("vec_valid", out_valid, 1);
      chk("vec_imm", out_imm, vecs[n].imm32);
      chk("vec_imm64", out_imm64, vecs[n].imm64);
      chk("vec_fmt", out_fmt, vecs[n].fmt);
      chk("vec_illegal", out_illegal, vecs[n].ill);
      chk("vec_tag", out_tag, 8'(n + 1));
      tick();
    end

    got.delete();
    begin
      int t = 1;
      for (int c = 0; c < 20 && (t <= 5 || q.size() > 0); c++) begin
        out_ready = c >= 4;
        in_valid = t <= 5;
        in_instr = 32'h00000013 | (32'(t) << 20);
        in_tag = 8'(t);
        if (in_valid && ir_seen_pred()) t++;
        tick();
        if (c == 2) chk("bp_ready_low", ir_seen, 0);
        if (c >= 1 && c <= 3) begin
          chk("bp_hold_valid", out_valid, 1);
          chk("bp_hold_tag", out_tag, 1);
          chk("bp_hold_imm", out_imm, 1);
        end
      end
      chk("bp_count", got.size(), 5);
      for (int k = 0; k < 5 && k < got.size(); k++) chk("bp_order", got[k], 8'(k + 1));
    end

    in_valid = 1'b1; out_ready = 1'b0; in_instr = 32'hFFF00093;
    in_tag = 8'h10; tick();
    in_tag = 8'h11; tick();
    flush = 1'b1; in_tag = 8'hAA; tick();
    chk("flush_ready", ir_seen, 0);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    tick();
    out_ready = 1'b1; in_valid = 1'b1; in_tag = 8'h20; tick();
    in_valid = 1'b0;
    chk("flush_next_early", out_valid, 0);
    tick();
    chk("flush_next_valid", out_valid, 1);
    chk("flush_next_tag", out_tag, 8'h20);
    tick();

    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFE112E23;
    in_tag = 8'h30; tick();
    in_tag = 8'h31; tick();
    in_valid = 1'b0;
    chk("pre_reset_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    for (int c = 0; c < 400; c++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      in_instr = $urandom();
      if ($urandom_range(0, 7) != 0) in_instr[6:0] = ops[$urandom_range(0, 10)];
      in_tag = 8'($urandom());
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    chk("drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Model-side prediction of acceptance for the stimulus sequencer (no DUT read)
  function automatic bit ir_seen_pred();
    return !flush && (q.size() < 2 || out_ready);
  endfunction
endmodule
